gem_ext_fifo_tx_arb: RTL and testbench

//  Packet-atomic round-robin arbiter sharing one GEM ext-FIFO TX adapter between N_SRC AXI4-Stream byte sources.

---
 rtl/gem_ext_fifo_pkg.sv | 18 +
 rtl/gem_rr_pick.sv | 31 +++
 rtl/gem_ext_fifo_tx_arb.sv | 141 ++++++++++++++
 tb/tb_gem_ext_fifo_tx_arb.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gem_ext_fifo_pkg.sv
// Shared types and constants for the GEM ext-FIFO TX arbiter and
// its round-robin picker.
package gem_ext_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_XFER      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_st_e;

  localparam int TID_W = 8;

  // Candidate index k steps past the pointer, wrapped to n sources.
  function automatic int rr_next(int p, int k, int n);
    return (p + k) % n;
  endfunction

endpackage

// File: rtl/gem_rr_pick.sv
// Combinational round-robin picker: scans upward from ptr_i+1.
// Ports: req_i, ptr_i in; gnt_o one-hot, idx_o, vld_o out.
module gem_rr_pick
  import gem_ext_fifo_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = rr_next(int'(ptr_i), k, N);
      if (!vld_o && req_i[j]) begin
        vld_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/gem_ext_fifo_tx_arb.sv
// Packet-atomic round-robin arbiter sharing one ext-FIFO TX adapter.
// Ports: s_axis_* per source, m_axis_* to adapter, tx_done_tog_i, status.
module gem_ext_fifo_tx_arb
  import gem_ext_fifo_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int WAIT_DONE_EN = 1,
  parameter int TIMEOUT_CYC  = 4096,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [8*N_SRC-1:0] s_axis_tdata,
  input  logic [N_SRC-1:0]   s_axis_tvalid,
  input  logic [N_SRC-1:0]   s_axis_tlast,
  output logic [N_SRC-1:0]   s_axis_tready,
  output logic [7:0]         m_axis_tdata,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  output logic [TID_W-1:0]   m_axis_tid,
  input  logic               m_axis_tready,
  input  logic               tx_done_tog_i,
  output logic [N_SRC-1:0]   grant_o,
  output logic               busy_o,
  output logic               done_timeout_o,
  output logic [CNT_W-1:0]   pkt_cnt_o
);

  localparam int IW = $clog2(N_SRC);
  localparam int TW = $clog2(TIMEOUT_CYC);

  arb_st_e            st_q, st_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               to_q, to_d;
  logic               tog_q;

  logic [N_SRC-1:0]   pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_vld;
  logic               evt;
  logic [N_SRC-1:0]   rdy;

  gem_rr_pick #(
    .N  (N_SRC),
    .IW (IW)
  ) u_pick (
    .req_i (s_axis_tvalid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  assign evt = tx_done_tog_i ^ tog_q;

  always_comb begin
    st_d          = st_q;
    grant_d       = grant_q;
    idx_d         = idx_q;
    ptr_d         = ptr_q;
    tmr_d         = tmr_q;
    cnt_d         = cnt_q;
    to_d          = 1'b0;
    rdy           = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tid    = '0;
    unique case (st_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_gnt;
          idx_d   = pick_idx;
          ptr_d   = pick_idx;
          st_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        m_axis_tvalid = s_axis_tvalid[idx_q];
        m_axis_tlast  = s_axis_tlast[idx_q];
        m_axis_tdata  = s_axis_tdata[{idx_q, 3'b000} +: 8];
        m_axis_tid    = TID_W'(idx_q);
        rdy[idx_q]    = m_axis_tready;
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          cnt_d   = cnt_q + CNT_W'(1);
          grant_d = '0;
          tmr_d   = '0;
          st_d    = (WAIT_DONE_EN != 0) ? ST_WAIT_DONE : ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        // A completion event takes priority over a same-cycle expiry.
        if (evt) begin
          st_d = ST_IDLE;
        end else if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
          st_d = ST_IDLE;
          to_d = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        st_d    = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q    <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= IW'(N_SRC - 1);
      tmr_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      tog_q   <= tx_done_tog_i;
    end else begin
      st_q    <= st_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      tog_q   <= tx_done_tog_i;
    end
  end

  assign s_axis_tready  = rdy;
  assign grant_o        = grant_q;
  assign busy_o         = (st_q != ST_IDLE);
  assign done_timeout_o = to_q;
  assign pkt_cnt_o      = cnt_q;

endmodule

// File: tb/tb_gem_ext_fifo_tx_arb.sv
// Directed bench for gem_ext_fifo_tx_arb: three configurations share
// the source stimulus; sel chooses which one the source model follows.
module tb_gem_ext_fifo_tx_arb;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid;
  logic [3:0]  s_tlast;
  logic        m_ready;
  logic        tog;
  int          sel;

  logic [3:0]  a_rdy, w_rdy, t_rdy;
  logic [7:0]  a_md, w_md, t_md;
  logic        a_mv, w_mv, t_mv;
  logic        a_ml, w_ml, t_ml;
  logic [7:0]  a_id, w_id, t_id;
  logic [3:0]  a_g, w_g, t_g;
  logic        a_b, w_b, t_b;
  logic        a_to, w_to, t_to;
  logic [15:0] a_c, w_c, t_c;

  logic [3:0]  c_rdy, c_g;
  logic [7:0]  c_md, c_id;
  logic        c_mv, c_ml, c_b, c_to;
  logic [15:0] c_c;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  d;
    logic        l;
    logic [7:0]  id;
  } beat_t;

  beat_t      ob[$];
  logic [8:0] sq[4][$];
  int         ncyc, tests, fails, to_n, to_at;

  always #5 clk = ~clk;

  gem_ext_fifo_tx_arb #(.N_SRC(4), .WAIT_DONE_EN(0)) u_imm (
    .clk(clk), .rstn(rstn), .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(a_rdy), .m_axis_tdata(a_md),
    .m_axis_tvalid(a_mv), .m_axis_tlast(a_ml), .m_axis_tid(a_id),
    .m_axis_tready(m_ready), .tx_done_tog_i(tog), .grant_o(a_g),
    .busy_o(a_b), .done_timeout_o(a_to), .pkt_cnt_o(a_c)
  );

  gem_ext_fifo_tx_arb #(.N_SRC(4), .WAIT_DONE_EN(1),
                        .TIMEOUT_CYC(64)) u_wait (
    .clk(clk), .rstn(rstn), .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(w_rdy), .m_axis_tdata(w_md),
    .m_axis_tvalid(w_mv), .m_axis_tlast(w_ml), .m_axis_tid(w_id),
    .m_axis_tready(m_ready), .tx_done_tog_i(tog), .grant_o(w_g),
    .busy_o(w_b), .done_timeout_o(w_to), .pkt_cnt_o(w_c)
  );

  gem_ext_fifo_tx_arb #(.N_SRC(4), .WAIT_DONE_EN(1),
                        .TIMEOUT_CYC(8)) u_to (
    .clk(clk), .rstn(rstn), .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(t_rdy), .m_axis_tdata(t_md),
    .m_axis_tvalid(t_mv), .m_axis_tlast(t_ml), .m_axis_tid(t_id),
    .m_axis_tready(m_ready), .tx_done_tog_i(tog), .grant_o(t_g),
    .busy_o(t_b), .done_timeout_o(t_to), .pkt_cnt_o(t_c)
  );

  always_comb begin
    c_rdy = t_rdy; c_md = t_md; c_mv = t_mv; c_ml = t_ml;
    c_id = t_id; c_g = t_g; c_b = t_b; c_to = t_to; c_c = t_c;
    if (sel == 0) begin
      c_rdy = a_rdy; c_md = a_md; c_mv = a_mv; c_ml = a_ml;
      c_id = a_id; c_g = a_g; c_b = a_b; c_to = a_to; c_c = a_c;
    end else if (sel == 1) begin
      c_rdy = w_rdy; c_md = w_md; c_mv = w_mv; c_ml = w_ml;
      c_id = w_id; c_g = w_g; c_b = w_b; c_to = w_to; c_c = w_c;
    end
  end

  task automatic drive();
    logic [8:0] h;
    for (int i = 0; i < 4; i++) begin
      if (sq[i].size() > 0) begin
        h = sq[i][0];
        s_tvalid[i] = 1'b1;
        s_tdata[8*i +: 8] = h[7:0];
        s_tlast[i] = h[8];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tdata[8*i +: 8] = 8'h00;
        s_tlast[i] = 1'b0;
      end
    end
  endtask

  task automatic push(input int s, input logic [7:0] d, input logic l);
    sq[s].push_back({l, d});
  endtask

  // One clock: sample just before the edge, then advance the sources.
  task automatic cyc();
    logic [3:0] hs;
    beat_t b;
    #1;
    hs = s_tvalid & c_rdy;
    if (c_mv && m_ready) begin
      b.cyc = ncyc; b.d = c_md; b.l = c_ml; b.id = c_id;
      ob.push_back(b);
    end
    if (c_to) begin
      to_n++;
      to_at = ncyc;
    end
    @(posedge clk);
    @(negedge clk);
    ncyc++;
    for (int i = 0; i < 4; i++)
      if (hs[i]) void'(sq[i].pop_front());
    drive();
  endtask

  task automatic do_reset(input int s);
    sel = s;
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    ob.delete();
    to_n = 0;
  endtask

  task automatic test_reset();
    s_tvalid = 4'hF;
    s_tlast = 4'hF;
    @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      tests++;
      if (c_rdy !== 4'h0 || c_mv !== 1'b0 || c_ml !== 1'b0) begin
        fails++;
        $display("FAIL reset_hs sel=%0d rdy=%0h mv=%0b ml=%0b want 0 0 0",
                 s, c_rdy, c_mv, c_ml);
      end
      tests++;
      if (c_g !== 4'h0 || c_b !== 1'b0 || c_to !== 1'b0 ||
          c_c !== 16'h0) begin
        fails++;
        $display("FAIL reset_st sel=%0d g=%0h b=%0b to=%0b cnt=%0d want 0",
                 s, c_g, c_b, c_to, c_c);
      end
    end
    drive();
    rstn = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    int c0;
    do_reset(1);
    for (int i = 0; i < 5; i++) push(0, 8'h10 + 8'(i), i == 4);
    drive();
    c0 = ncyc;
    cyc();
    #1;
    tests++;
    if (c_g !== 4'b0001 || c_b !== 1'b1) begin
      fails++;
      $display("FAIL single_grant g=%0h b=%0b want 1 1", c_g, c_b);
    end
    repeat (5) cyc();
    tests++;
    if (ob.size() != 5) begin
      fails++;
      $display("FAIL single_beats got=%0d want=5", ob.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (ob[i].cyc != 32'(c0 + 1 + i) || ob[i].d !== 8'h10 + 8'(i) ||
            ob[i].l !== (i == 4) || ob[i].id !== 8'h00) begin
          fails++;
          $display("FAIL single_beat%0d got c=%0d d=%0h l=%0b id=%0h want c=%0d d=%0h l=%0b id=0",
                   i, ob[i].cyc - c0, ob[i].d, ob[i].l, ob[i].id,
                   1 + i, 8'h10 + 8'(i), i == 4);
        end
      end
    end
    tests++;
    if (c_c !== 16'd1 || c_g !== 4'h0 || c_b !== 1'b1) begin
      fails++;
      $display("FAIL single_end cnt=%0d g=%0h b=%0b want 1 0 1",
               c_c, c_g, c_b);
    end
  endtask

  task automatic test_wait_done();
    int t;
    do_reset(1);
    push(0, 8'hA0, 1'b0);
    push(0, 8'hA1, 1'b1);
    drive();
    cyc();
    push(1, 8'hB0, 1'b0);
    push(1, 8'hB1, 1'b1);
    drive();
    cyc();
    t = ncyc;
    cyc();
    repeat (9) cyc();
    #1;
    tests++;
    if (ob.size() != 2 || c_b !== 1'b1 || c_g !== 4'h0) begin
      fails++;
      $display("FAIL wait_hold beats=%0d b=%0b g=%0h want 2 1 0",
               ob.size(), c_b, c_g);
    end
    tog = ~tog;
    repeat (4) cyc();
    tests++;
    if (ob.size() != 4) begin
      fails++;
      $display("FAIL wait_beats got=%0d want=4", ob.size());
    end else begin
      tests++;
      if (ob[2].cyc != 32'(t + 12) || ob[2].id !== 8'h01 ||
          ob[2].d !== 8'hB0 || ob[3].d !== 8'hB1 || ob[3].l !== 1'b1) begin
        fails++;
        $display("FAIL wait_src1 got c=%0d id=%0h d=%0h,%0h want c=12 id=1 d=b0,b1",
                 ob[2].cyc - t, ob[2].id, ob[2].d, ob[3].d);
      end
    end
  endtask

  task automatic test_timeout();
    int c0;
    do_reset(2);
    push(0, 8'hC0, 1'b1);
    push(1, 8'hD0, 1'b1);
    drive();
    c0 = ncyc;
    repeat (13) cyc();
    tests++;
    if (to_n != 1 || to_at != c0 + 10) begin
      fails++;
      $display("FAIL timeout_pulse got n=%0d at=%0d want n=1 at=10",
               to_n, to_at - c0);
    end
    tests++;
    if (ob.size() != 2) begin
      fails++;
      $display("FAIL timeout_beats got=%0d want=2", ob.size());
    end else begin
      tests++;
      if (ob[1].cyc != 32'(c0 + 11) || ob[1].id !== 8'h01 ||
          ob[1].d !== 8'hD0) begin
        fails++;
        $display("FAIL timeout_resume got c=%0d id=%0h d=%0h want c=11 id=1 d=d0",
                 ob[1].cyc - c0, ob[1].id, ob[1].d);
      end
    end
  endtask

  task automatic test_tog_expiry();
    int c0;
    do_reset(2);
    tog = ~tog;
    repeat (2) cyc();
    push(0, 8'hE0, 1'b1);
    drive();
    c0 = ncyc;
    repeat (7) cyc();
    #1;
    tests++;
    if (c_b !== 1'b1) begin
      fails++;
      $display("FAIL absorb_tog busy=%0b want 1", c_b);
    end
    repeat (2) cyc();
    tog = ~tog;
    repeat (4) cyc();
    tests++;
    if (to_n != 0 || c_b !== 1'b0 || ob.size() != 1) begin
      fails++;
      $display("FAIL tog_expiry to_n=%0d b=%0b beats=%0d want 0 0 1",
               to_n, c_b, ob.size());
    end
  endtask

  task automatic test_ready_toggle();
    do_reset(0);
    for (int i = 0; i < 6; i++) push(2, 8'h60 + 8'(i), i == 5);
    drive();
    for (int k = 0; k < 16; k++) begin
      m_ready = (k % 2 == 0);
      cyc();
    end
    m_ready = 1'b1;
    tests++;
    if (ob.size() != 6 || c_c !== 16'd1) begin
      fails++;
      $display("FAIL rdy_toggle beats=%0d cnt=%0d want 6 1",
               ob.size(), c_c);
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (ob[i].d !== 8'h60 + 8'(i) || ob[i].l !== (i == 5) ||
            ob[i].id !== 8'h02) begin
          fails++;
          $display("FAIL rdy_beat%0d got d=%0h l=%0b id=%0h want d=%0h",
                   i, ob[i].d, ob[i].l, ob[i].id, 8'h60 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int c0;
    logic [7:0] ed[10];
    int eo[10];
    ed = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20,
           8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
    eo = '{1, 2, 4, 5, 7, 8, 10, 11, 13, 14};
    do_reset(0);
    for (int s = 0; s < 4; s++) begin
      push(s, 8'(s * 16), 1'b0);
      push(s, 8'(s * 16 + 1), 1'b1);
    end
    push(0, 8'h02, 1'b0);
    push(0, 8'h03, 1'b1);
    drive();
    c0 = ncyc;
    repeat (16) cyc();
    tests++;
    if (ob.size() != 10 || c_c !== 16'd5) begin
      fails++;
      $display("FAIL rr_count beats=%0d cnt=%0d want 10 5",
               ob.size(), c_c);
    end else begin
      for (int i = 0; i < 10; i++) begin
        tests++;
        if (ob[i].d !== ed[i] || ob[i].cyc != 32'(c0 + eo[i]) ||
            ob[i].id !== {4'h0, ed[i][7:4]} || ob[i].l !== (i % 2 == 1)) begin
          fails++;
          $display("FAIL rr_beat%0d got d=%0h c=%0d id=%0h want d=%0h c=%0d",
                   i, ob[i].d, ob[i].cyc - c0, ob[i].id, ed[i], eo[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    do_reset(1);
    for (int i = 0; i < 6; i++) push(1, 8'h70 + 8'(i), i == 5);
    drive();
    repeat (3) cyc();
    rstn = 1'b0;
    cyc();
    #1;
    tests++;
    if (c_rdy !== 4'h0 || c_mv !== 1'b0 || c_g !== 4'h0 ||
        c_b !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset rdy=%0h mv=%0b g=%0h b=%0b want 0",
               c_rdy, c_mv, c_g, c_b);
    end
    sq[1].delete();
    rstn = 1'b1;
    push(0, 8'h80, 1'b1);
    push(2, 8'h90, 1'b1);
    drive();
    ob.delete();
    c0 = ncyc;
    repeat (3) cyc();
    tests++;
    if (ob.size() == 0) begin
      fails++;
      $display("FAIL post_reset beats=0 want>=1");
    end else begin
      tests++;
      if (ob[0].id !== 8'h00 || ob[0].d !== 8'h80 ||
          ob[0].cyc != 32'(c0 + 1)) begin
        fails++;
        $display("FAIL post_reset_first got id=%0h d=%0h c=%0d want 0 80 1",
                 ob[0].id, ob[0].d, ob[0].cyc - c0);
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    s_tdata = '0;
    s_tvalid = '0;
    s_tlast = '0;
    m_ready = 1'b1;
    tog = 1'b0;
    sel = 1;
    ncyc = 0;
    tests = 0;
    fails = 0;
    to_n = 0;
    to_at = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_wait_done();
    test_timeout();
    test_tog_expiry();
    test_ready_toggle();
    test_round_robin();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
